// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong group buffer controller.
// Holds the default widths, the group size and the FILL/FULL state encoding
// used by pp_bank_fsm and pingpong_buf_ctrl, plus the saturating increment
// used by the optional error counters (PINGPONG_ERRCNT_EN).
package pingpong_pkg;

  localparam int unsigned DATA_W_DEF    = 12;
  localparam int unsigned ADDR_W_DEF    = 10;
  localparam int unsigned GRP_WORDS_DEF = 1024;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } pp_state_t;

  localparam logic [7:0] ERRCNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERRCNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pp_bank_fsm.sv
// FILL/FULL bank ownership FSM for the ping-pong controller.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_valid, wr_last     filler word strobe and early group close
//   rd_swap               frame-boundary pulse from the frame former
//   accept                comb: the current wr_valid word is taken
//   wr_ptr                address for the accepted word
//   wr_bank               bank currently owned by the writer
//   swap_ack/underrun/overrun  registered one-cycle event pulses
module pp_bank_fsm
  import pingpong_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned GRP_WORDS = GRP_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic              wr_last,
  input  logic              rd_swap,
  output logic              accept,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wr_bank,
  output logic              swap_ack,
  output logic              underrun,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(GRP_WORDS - 1);

  pp_state_t state;
  logic      at_max;
  logic      closing;
  logic      do_swap;

  assign accept  = (state == FILL) && wr_valid;
  assign at_max  = (wr_ptr == PTR_MAX);
  assign closing = accept && (at_max || wr_last);
  // A group closed by this very write is swappable in the same cycle; the
  // closing word is still tagged with the old bank by the write stage.
  assign do_swap = rd_swap && ((state == FULL) || closing);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      wr_ptr   <= '0;
      wr_bank  <= 1'b0;
      swap_ack <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      swap_ack <= do_swap;
      underrun <= rd_swap && !do_swap;
      overrun  <= wr_valid && (state == FULL);
      if (do_swap) begin
        wr_bank <= ~wr_bank;
        wr_ptr  <= '0;
        state   <= FILL;
      end else if (accept) begin
        // Pointer stops at the last address rather than wrapping.
        if (!at_max) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
        if (closing) begin
          state <= FULL;
        end
      end
    end
  end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong group buffer controller between the telemetry word filler and
// the M8 frame former. The writer fills one bank while the reader consumes
// the other; roles swap on rd_swap once the write bank is complete.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wr_word/wr_valid/wr_last    filler write interface
//   rd_en/rd_addr/rd_swap       frame former read interface
//   rd_data/rd_valid            read data, 1 clk after rd_en
//   m0_we/m1_we/m_wadr/m_wdat   registered bank write port
//   m0_re/m1_re/m_radr          combinational bank read port
//   m0_q/m1_q                   bank read data (1 clk RAM latency)
//   wr_bank                     bank owned by the writer
//   swap_ack/underrun/overrun   one-cycle event pulses
//   ovr_cnt/und_cnt             saturating error counters
// Build option: define PINGPONG_ERRCNT_EN to build the error counters;
// otherwise both counters read 0.
module pingpong_buf_ctrl
  import pingpong_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned GRP_WORDS = GRP_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_word,
  input  logic              wr_valid,
  input  logic              wr_last,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_swap,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              m0_we,
  output logic              m1_we,
  output logic [ADDR_W-1:0] m_wadr,
  output logic [DATA_W-1:0] m_wdat,
  output logic              m0_re,
  output logic              m1_re,
  output logic [ADDR_W-1:0] m_radr,
  input  logic [DATA_W-1:0] m0_q,
  input  logic [DATA_W-1:0] m1_q,
  output logic              wr_bank,
  output logic              swap_ack,
  output logic              underrun,
  output logic              overrun,
  output logic [7:0]        ovr_cnt,
  output logic [7:0]        und_cnt
);

  logic              accept;
  logic [ADDR_W-1:0] wr_ptr;
  logic              rd_sel;

  pp_bank_fsm #(
    .ADDR_W   (ADDR_W),
    .GRP_WORDS(GRP_WORDS)
  ) u_fsm (
    .clk     (clk),
    .reset   (reset),
    .wr_valid(wr_valid),
    .wr_last (wr_last),
    .rd_swap (rd_swap),
    .accept  (accept),
    .wr_ptr  (wr_ptr),
    .wr_bank (wr_bank),
    .swap_ack(swap_ack),
    .underrun(underrun),
    .overrun (overrun)
  );

  // Write stage: bank chosen from wr_bank before any swap on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_we  <= 1'b0;
      m1_we  <= 1'b0;
      m_wadr <= '0;
      m_wdat <= '0;
    end else begin
      m0_we <= accept && !wr_bank;
      m1_we <= accept && wr_bank;
      if (accept) begin
        m_wadr <= wr_ptr;
        m_wdat <= wr_word;
      end
    end
  end

  // Read path: the reader always owns the bank the writer does not.
  assign m0_re  = rd_en && wr_bank;
  assign m1_re  = rd_en && !wr_bank;
  assign m_radr = rd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_sel   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel <= !wr_bank;
      end
    end
  end

  assign rd_data = rd_valid ? (rd_sel ? m1_q : m0_q) : '0;

`ifdef PINGPONG_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt <= '0;
      und_cnt <= '0;
    end else begin
      if (overrun) begin
        ovr_cnt <= sat_inc(ovr_cnt);
      end
      if (underrun) begin
        und_cnt <= sat_inc(und_cnt);
      end
    end
  end
`else
  assign ovr_cnt = '0;
  assign und_cnt = '0;
`endif

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Bench for pingpong_buf_ctrl: hand table, directed corner sequences and
// randomized traffic checked against a group-count reference model.
module tb_pingpong_buf_ctrl;

`ifdef PINGPONG_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int GRP = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] wr_word;
  logic        wr_valid, wr_last, rd_en, rd_swap;
  logic [9:0]  rd_addr;
  logic [11:0] rd_data;
  logic        rd_valid, m0_we, m1_we, m0_re, m1_re;
  logic [9:0]  m_wadr, m_radr;
  logic [11:0] m_wdat;
  logic [11:0] m0_q = '0;
  logic [11:0] m1_q = '0;
  logic        wr_bank, swap_ack, underrun, overrun;
  logic [7:0]  ovr_cnt, und_cnt;

  int checks = 0;
  int errors = 0;

  pingpong_buf_ctrl #(.DATA_W(12), .ADDR_W(10), .GRP_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .wr_word(wr_word), .wr_valid(wr_valid),
    .wr_last(wr_last), .rd_en(rd_en), .rd_addr(rd_addr), .rd_swap(rd_swap),
    .rd_data(rd_data), .rd_valid(rd_valid), .m0_we(m0_we), .m1_we(m1_we),
    .m_wadr(m_wadr), .m_wdat(m_wdat), .m0_re(m0_re), .m1_re(m1_re),
    .m_radr(m_radr), .m0_q(m0_q), .m1_q(m1_q), .wr_bank(wr_bank),
    .swap_ack(swap_ack), .underrun(underrun), .overrun(overrun),
    .ovr_cnt(ovr_cnt), .und_cnt(und_cnt)
  );

  always #5 clk = ~clk;

  // Bank RAMs with 1-clk read latency, read-before-write.
  logic [11:0] ram0 [GRP];
  logic [11:0] ram1 [GRP];
  always @(posedge clk) begin
    if (m0_re) m0_q <= ram0[m_radr];
    if (m1_re) m1_q <= ram1[m_radr];
    if (m0_we) ram0[m_wadr] <= m_wdat;
    if (m1_we) ram1[m_wadr] <= m_wdat;
  end

  // Reference model: group contents and word counts per bank.
  logic [11:0] exp_mem [2][GRP];
  int          m_bank, m_cnt;
  bit          m_full;
  bit          pend_we;
  int          pend_bank, pend_addr;
  logic [11:0] pend_data;
  bit          e_we0, e_we1, e_ack, e_und, e_ovr, e_rv;
  int          e_wadr;
  logic [11:0] e_wdat, e_rdata;
  int          e_ocnt, e_ucnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit acc, closing, swp;
    // A read sees memory as it was before a write landing on the same edge.
    if (!reset && rd_en) e_rdata = exp_mem[1 - m_bank][rd_addr];
    if (pend_we) exp_mem[pend_bank][pend_addr] = pend_data;
    if (reset) begin
      m_bank = 0; m_cnt = 0; m_full = 0; pend_we = 0;
      e_we0 = 0; e_we1 = 0; e_ack = 0; e_und = 0; e_ovr = 0; e_rv = 0;
      e_ocnt = 0; e_ucnt = 0;
      return;
    end
    e_rv    = rd_en;
    acc     = wr_valid && !m_full;
    closing = acc && ((m_cnt + 1 == GRP) || wr_last);
    swp     = rd_swap && (m_full || closing);
    e_we0   = acc && (m_bank == 0);
    e_we1   = acc && (m_bank == 1);
    if (acc) begin
      e_wadr = m_cnt; e_wdat = wr_word;
    end
    pend_we = acc; pend_bank = m_bank; pend_addr = m_cnt; pend_data = wr_word;
    e_ovr = wr_valid && m_full;
    e_und = rd_swap && !swp;
    e_ack = swp;
    if (e_ovr && e_ocnt < 255) e_ocnt++;
    if (e_und && e_ucnt < 255) e_ucnt++;
    if (swp) begin
      m_bank = 1 - m_bank; m_cnt = 0; m_full = 0;
    end else if (acc) begin
      m_cnt++;
      if (closing) m_full = 1;
    end
  endfunction

  task automatic check_regs();
    chk("m0_we", m0_we, e_we0);
    chk("m1_we", m1_we, e_we1);
    if (e_we0 || e_we1) begin
      chk("m_wadr", m_wadr, e_wadr);
      chk("m_wdat", m_wdat, e_wdat);
    end
    chk("wr_bank", wr_bank, m_bank);
    chk("swap_ack", swap_ack, e_ack);
    chk("underrun", underrun, e_und);
    chk("overrun", overrun, e_ovr);
    chk("rd_valid", rd_valid, e_rv);
    if (e_rv) chk("rd_data", rd_data, e_rdata);
    chk("ovr_cnt", ovr_cnt, CNT_EN ? e_ocnt : 0);
    chk("und_cnt", und_cnt, CNT_EN ? e_ucnt : 0);
  endtask

  // One clock: drive, check read enables before the edge, check state after.
  task automatic cycle(input logic rst, input logic wv, input logic wl, input logic re,
                       input logic sw, input logic [9:0] ra, input logic [11:0] wd);
    reset = rst; wr_valid = wv; wr_last = wl; rd_en = re; rd_swap = sw;
    rd_addr = ra; wr_word = wd;
    #2;
    chk("m0_re", m0_re, re && (m_bank == 1));
    chk("m1_re", m1_re, re && (m_bank == 0));
    if (re) chk("m_radr", m_radr, ra);
    @(posedge clk);
    model_step();
    #1;
    check_regs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_m0_we"}, m0_we, 0);
    chk({tag, "_m1_we"}, m1_we, 0);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_swap_ack"}, swap_ack, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_ovr_cnt"}, ovr_cnt, 0);
    chk({tag, "_und_cnt"}, und_cnt, 0);
  endtask

  typedef struct {
    logic       wv, wl, sw;
    logic [11:0] wd;
    logic       e_we0, e_we1;
    logic [9:0] e_wadr;
    logic       e_bank, e_ack, e_und, e_ovr;
    logic [7:0] e_ucnt, e_ocnt;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic wl, input logic sw, input logic [11:0] wd,
                              input logic we0, input logic we1, input logic [9:0] wadr,
                              input logic bank, input logic ack, input logic und, input logic ovr,
                              input logic [7:0] ucnt, input logic [7:0] ocnt);
    vec_t v;
    v.wv = wv; v.wl = wl; v.sw = sw; v.wd = wd; v.e_we0 = we0; v.e_we1 = we1;
    v.e_wadr = wadr; v.e_bank = bank; v.e_ack = ack; v.e_und = und; v.e_ovr = ovr;
    v.e_ucnt = ucnt; v.e_ocnt = ocnt;
    return v;
  endfunction

  vec_t vt [9];
  int   n_we, n_ovr;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < GRP; a++) exp_mem[b][a] = '0;
    for (int a = 0; a < GRP; a++) begin
      ram0[a] = '0; ram1[a] = '0;
    end
    m_bank = 0; m_cnt = 0; m_full = 0; pend_we = 0;
    e_ocnt = 0; e_ucnt = 0; e_rdata = '0; e_wadr = 0; e_wdat = '0;
    reset = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_swap = 1'b0;
    rd_addr = '0; wr_word = '0;
    @(posedge clk); #1;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 12'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 12'd0);
    check_reset_state("reset");

    // Table: 3 writes, early swap (underrun), wr_last close, overrun, swap, write to bank 1
    vt[0] = mk(1'b1, 1'b0, 1'b0, 12'h100, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    vt[1] = mk(1'b1, 1'b0, 1'b0, 12'h101, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    vt[2] = mk(1'b1, 1'b0, 1'b0, 12'h102, 1'b1, 1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    vt[3] = mk(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    vt[4] = mk(1'b1, 1'b1, 1'b0, 12'h103, 1'b1, 1'b0, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
    vt[5] = mk(1'b1, 1'b0, 1'b0, 12'h104, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
    vt[6] = mk(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);
    vt[7] = mk(1'b1, 1'b0, 1'b0, 12'h105, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    vt[8] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, vt[i].wv, vt[i].wl, 1'b0, vt[i].sw, 10'd0, vt[i].wd);
      chk("tbl_m0_we", m0_we, vt[i].e_we0);
      chk("tbl_m1_we", m1_we, vt[i].e_we1);
      if (vt[i].e_we0 || vt[i].e_we1) chk("tbl_m_wadr", m_wadr, vt[i].e_wadr);
      chk("tbl_wr_bank", wr_bank, vt[i].e_bank);
      chk("tbl_swap_ack", swap_ack, vt[i].e_ack);
      chk("tbl_underrun", underrun, vt[i].e_und);
      chk("tbl_overrun", overrun, vt[i].e_ovr);
      chk("tbl_und_cnt", und_cnt, CNT_EN ? vt[i].e_ucnt : 8'd0);
      chk("tbl_ovr_cnt", ovr_cnt, CNT_EN ? vt[i].e_ocnt : 8'd0);
    end

    // Full group of 1024 words into bank 0, then swap
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 12'd0);
    n_we = 0;
    for (int i = 0; i < GRP; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 12'(i));
      if (m0_we) n_we++;
    end
    chk("t1_we_count", n_we, GRP);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 12'hABC);
    chk("t1_full_overrun", overrun, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 12'd0);
    chk("t1_swap_ack", swap_ack, 1);
    chk("t1_wr_bank", wr_bank, 1);

    // Read addr 5 from the now-read bank 0
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd5, 12'd0);
    chk("t2_rd_valid", rd_valid, 1);
    chk("t2_rd_data", rd_data, 12'd5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 12'd0);
    chk("t2_rd_valid_drop", rd_valid, 0);

    // Close bank 1 with one word, then 300 writes into a full bank
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 12'h055);
    n_ovr = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 12'($urandom));
      if (overrun) n_ovr++;
    end
    chk("t5_overrun_count", n_ovr, 300);
    chk("t5_ovr_cnt_sat", ovr_cnt, CNT_EN ? 8'hFF : 8'h00);

    // Swap to bank 0, two words, then closing write + swap + read together
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 12'd0);
    chk("t6_swap_bank0", wr_bank, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 12'h770);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 12'h771);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 12'h777);
    chk("t6_old_bank_we", m0_we, 1);
    chk("t6_old_bank_wadr", m_wadr, 2);
    chk("t6_swap_ack", swap_ack, 1);
    chk("t6_wr_bank", wr_bank, 1);
    chk("t6_rd_data_old_bank", rd_data, 12'h055);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 12'(i));
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd3, 12'hFFF);
    check_reset_state("t6_mid_reset");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 29) == 0, 10'($urandom), 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
